// File: rtl/layer_mixer.sv
// Priority compositor for N_LAYERS sprite layers over a background colour, with
// per-pair overlap detection folded into once-per-frame collision events.
module layer_mixer #(
    parameter int               N_LAYERS     = 4,
    parameter int               RGB_W        = 12,
    parameter logic [RGB_W-1:0] BG_RGB       = 12'h000,
    parameter logic             VSYNC_ACTIVE = 1'b0
) (
    input  logic                        clk_vga,
    input  logic                        rst,
    input  logic                        disp_i,
    input  logic                        v_sync_i,
    input  logic [N_LAYERS*RGB_W-1:0]   rgb_i,
    input  logic [N_LAYERS-1:0]         alpha_i,
    input  logic [N_LAYERS-1:0]         layer_en_i,
    output logic [RGB_W-1:0]            rgb_o,
    output logic [N_LAYERS*(N_LAYERS-1)/2-1:0] crash_pulse_o,
    output logic [N_LAYERS*(N_LAYERS-1)/2-1:0] crash_first_o,
    output logic [N_LAYERS*(N_LAYERS-1)/2-1:0] crash_frame_o
);

    localparam int N_PAIRS = N_LAYERS*(N_LAYERS-1)/2;

    logic [N_LAYERS*RGB_W-1:0] rgb_p1;
    logic [N_LAYERS-1:0]       a_p1;
    logic                      disp_p1;
    logic                      vs_p1;
    logic                      vs_p2;
    logic [N_PAIRS-1:0]        acc;
    logic [N_PAIRS-1:0]        ov_p1;
    logic [N_PAIRS-1:0]        acc_base;
    logic [RGB_W-1:0]          rgb_mix;
    logic                      boundary;

    // Lowest-index opaque layer wins; blanking forces black regardless of layers.
    function automatic logic [RGB_W-1:0] compose(
        input logic                      disp,
        input logic [N_LAYERS-1:0]       a,
        input logic [N_LAYERS*RGB_W-1:0] rgb
    );
        logic [RGB_W-1:0] c;
        c = BG_RGB;
        for (int k = N_LAYERS-1; k >= 0; k--) begin
            if (a[k]) c = rgb[k*RGB_W +: RGB_W];
        end
        return disp ? c : '0;
    endfunction

    // Stage 1: register pixel inputs; disabled layers are folded into alpha here.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            rgb_p1  <= '0;
            a_p1    <= '0;
            disp_p1 <= 1'b0;
            vs_p1   <= ~VSYNC_ACTIVE;
        end else begin
            rgb_p1  <= rgb_i;
            a_p1    <= alpha_i & layer_en_i;
            disp_p1 <= disp_i;
            vs_p1   <= v_sync_i;
        end
    end

    always_comb begin
        int p;
        p     = 0;
        ov_p1 = '0;
        for (int i = 0; i < N_LAYERS-1; i++) begin
            for (int j = i+1; j < N_LAYERS; j++) begin
                ov_p1[p] = disp_p1 & a_p1[i] & a_p1[j];
                p++;
            end
        end
    end

    // A hit on the boundary edge belongs to both the closing and the new frame.
    assign boundary = (vs_p1 == VSYNC_ACTIVE) && (vs_p2 != VSYNC_ACTIVE);
    assign acc_base = boundary ? '0 : acc;
    assign rgb_mix  = compose(disp_p1, a_p1, rgb_p1);

    // Stage 2: composited pixel, collision events and per-frame accumulation.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            vs_p2         <= ~VSYNC_ACTIVE;
            acc           <= '0;
            rgb_o         <= '0;
            crash_pulse_o <= '0;
            crash_first_o <= '0;
            crash_frame_o <= '0;
        end else begin
            vs_p2         <= vs_p1;
            acc           <= acc_base | ov_p1;
            rgb_o         <= rgb_mix;
            crash_pulse_o <= ov_p1;
            crash_first_o <= ov_p1 & ~acc_base;
            if (boundary) crash_frame_o <= acc | ov_p1;
        end
    end

endmodule
